instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Inverse of the decode stage: turns a structured request (op, rd, rs1, rs2, imm) into raw 32-bit RV64I instruction words.
- Expands the LI pseudo-op into a LUI+ADDI sequence when the immediate needs it.
- Used by the self-test stimulus generator and the boot-ROM builder to feed the fetch path.
- Request side and output side each use a valid/ready handshake; output is a one-entry register stage.

Parameters:
- OPW, 5, width of req_op.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  encoder can accept a request this cycle
- req_op  in  OPW  0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 ADDI, 6 XORI, 7 ORI, 8 ANDI, 9 LD, 10 SD, 11 BEQ, 12 LUI, 13 AUIPC, 14 JAL, 15 JALR, 16 LI; 17–31 illegal
- req_rd  in  5  destination register
- req_rs1  in  5  source register 1
- req_rs2  in  5  source register 2
- req_imm  in  32  immediate, signed; LUI/AUIPC use bits [19:0] as the upper field
- out_valid  out  1  out_instr valid
- out_ready  in  1  consumer takes the word
- out_instr  out  32  encoded instruction
- out_last  out  1  final word of the current request
- err  out  1  one-cycle pulse: request rejected

Behaviour:
- Clock and reset: one clock `clk`; reset `resetn` is synchronous and active-low.
- Reset values: out_valid=0, out_instr=0, out_last=0, err=0, state=IDLE.
- Reset mid-sequence: a pending word and any second LI word are dropped; out_valid=0 the cycle after reset.
- States:
  - IDLE: output empty.
  - OUT0: holding the first or only word.
  - OUT1: holding the second LI word.
- req_ready = IDLE | (OUT0 & out_last & out_ready) | (OUT1 & out_ready). This gives back-to-back single-word throughput of 1 per cycle.
- Accept: req_valid & req_ready. The encoded word appears on out_instr with out_valid=1 the next cycle (latency 1).
- Legal accept: next state OUT0; out_last=1 unless the request is a two-word LI.
- OUT0 & out_ready & !out_last -> OUT1 with the second word, out_last=1.
- OUT0/OUT1 & out_ready & last, with no new accept -> IDLE, out_valid=0.
- Output stability: while out_valid & !out_ready, out_instr and out_last hold stable.
- Illegal request or out-of-range immediate:
  - err=1 the cycle after accept; nothing is emitted.
  - State goes to IDLE, or stays IDLE.
  - The request is consumed.
- Encodings (standard RV64I; fields the op does not use are driven 0):
  - R-type (opcode 0x33): funct7 0x20 for SUB, 0x00 otherwise.
  - I-ALU (opcode 0x13); LD (opcode 0x03, funct3 3); SD (opcode 0x23, funct3 3); BEQ (opcode 0x63, funct3 0).
  - LUI 0x37, AUIPC 0x17, JAL 0x6F, JALR 0x67 (funct3 0).
- Immediate range checks (signed); violation -> err:
  - I-type and S-type: [-2048, 2047].
  - BEQ: [-4096, 4094] and even.
  - JAL: [-2^20, 2^20-2] and even.
  - LUI/AUIPC: no check; bits [31:20] are ignored.
- LI rd, imm:
  - imm in [-2048, 2047]: one word, ADDI rd, x0, imm.
  - Otherwise: hi=(imm+0x800)[31:12], lo=imm[11:0].
    - Emit LUI rd, hi.
    - If lo≠0, then emit ADDI rd, rd, lo (lo is signed).
    - If lo==0, emit the LUI only, with out_last=1.
  - imm in 0x7FFFF800–0x7FFFFFFF: err. hi would wrap, and LUI sign-extension on RV64 then produces the wrong value.
- Simultaneous events: an accept in the same cycle as the last word's handshake loads the new word directly. out_valid stays 1 with no bubble.

Test Plan:
- ADDI rd=1 rs1=0 imm=5, out_ready=1 -> out_instr=0x00500093, out_last=1, one cycle after accept.
- LI rd=5 imm=0x12345678 -> 0x123452B7 (last=0), then 0x67828293 (last=1); req_ready=0 between the two words.
- LI rd=6 imm=0x1800 -> 0x00002337, then 0x80030313 (negative lo rounding).
- LI rd=5 imm=-1 -> single word 0xFFF00293. LI imm=0x10000 -> single LUI 0x000102B7 (rd=5), last=1.
- SD rs1=1 rs2=2 imm=8 with out_ready held 0 for 3 cycles -> 0x0020B423 stays stable; accepted on out_ready=1.
- Error cases, each -> err pulse, no out_valid: ADDI imm=2048; BEQ imm=3; LI imm=0x7FFFFFFF; op=20. Then reset asserted mid-LI (after the first word) -> out_valid=0 next cycle and no second word.

Source files
------------

// File: rtl/instr_encoder.sv
// RV64I instruction encoder: turns a structured request into raw 32-bit words.
// The LI pseudo-op expands to LUI+ADDI. The output is a one-entry valid/ready register stage.
module instr_encoder #(
   parameter int unsigned OPW = 5
) (
   input  logic           clk,
   input  logic           resetn,
   input  logic           req_valid,
   output logic           req_ready,
   input  logic [OPW-1:0] req_op,
   input  logic [4:0]     req_rd,
   input  logic [4:0]     req_rs1,
   input  logic [4:0]     req_rs2,
   input  logic [31:0]    req_imm,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [31:0]    out_instr,
   output logic           out_last,
   output logic           err
);

   localparam int unsigned OP_ADD   = 0;
   localparam int unsigned OP_SUB   = 1;
   localparam int unsigned OP_XOR   = 2;
   localparam int unsigned OP_OR    = 3;
   localparam int unsigned OP_AND   = 4;
   localparam int unsigned OP_ADDI  = 5;
   localparam int unsigned OP_XORI  = 6;
   localparam int unsigned OP_ORI   = 7;
   localparam int unsigned OP_ANDI  = 8;
   localparam int unsigned OP_LD    = 9;
   localparam int unsigned OP_SD    = 10;
   localparam int unsigned OP_BEQ   = 11;
   localparam int unsigned OP_LUI   = 12;
   localparam int unsigned OP_AUIPC = 13;
   localparam int unsigned OP_JAL   = 14;
   localparam int unsigned OP_JALR  = 15;
   localparam int unsigned OP_LI    = 16;

   localparam logic [6:0] OPC_OP     = 7'h33;
   localparam logic [6:0] OPC_OPIMM  = 7'h13;
   localparam logic [6:0] OPC_LOAD   = 7'h03;
   localparam logic [6:0] OPC_STORE  = 7'h23;
   localparam logic [6:0] OPC_BRANCH = 7'h63;
   localparam logic [6:0] OPC_LUI    = 7'h37;
   localparam logic [6:0] OPC_AUIPC  = 7'h17;
   localparam logic [6:0] OPC_JAL    = 7'h6F;
   localparam logic [6:0] OPC_JALR   = 7'h67;

   typedef enum logic [1:0] {IDLE, OUT0, OUT1} state_e;

   state_e             state_q, state_d;
   logic [31:0]        instr_q, instr_d;
   logic [31:0]        second_q, second_d;
   logic               last_q, last_d;
   logic               err_q, err_d;

   logic [31:0]        op_w;
   logic signed [31:0] simm;
   logic [11:0]        imm12;
   logic [19:0]        li_hi;
   logic [2:0]         f3_alu;
   logic               fits_i, fits_b, fits_j;
   logic [31:0]        enc0_c, enc1_c;
   logic               two_c, bad_c;
   logic               accept_c;

   // Combinational encode of the request currently on the input side
   always_comb begin
      op_w   = 32'(req_op);
      simm   = $signed(req_imm);
      imm12  = req_imm[11:0];
      li_hi  = 20'((req_imm + 32'h0000_0800) >> 12);
      fits_i = (simm >= -32'sd2048) && (simm <= 32'sd2047);
      fits_b = (simm >= -32'sd4096) && (simm <= 32'sd4094) && !req_imm[0];
      fits_j = (simm >= -32'sd1048576) && (simm <= 32'sd1048574) && !req_imm[0];

      case (op_w)
         OP_XOR, OP_XORI: f3_alu = 3'd4;
         OP_OR,  OP_ORI:  f3_alu = 3'd6;
         OP_AND, OP_ANDI: f3_alu = 3'd7;
         default:         f3_alu = 3'd0;
      endcase

      enc0_c = '0;
      enc1_c = '0;
      two_c  = 1'b0;
      bad_c  = 1'b0;
      case (op_w)
         OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_AND:
            enc0_c = {(op_w == OP_SUB) ? 7'h20 : 7'h00, req_rs2, req_rs1, f3_alu, req_rd, OPC_OP};
         OP_ADDI, OP_XORI, OP_ORI, OP_ANDI: begin
            bad_c  = !fits_i;
            enc0_c = {imm12, req_rs1, f3_alu, req_rd, OPC_OPIMM};
         end
         OP_LD: begin
            bad_c  = !fits_i;
            enc0_c = {imm12, req_rs1, 3'd3, req_rd, OPC_LOAD};
         end
         OP_SD: begin
            bad_c  = !fits_i;
            enc0_c = {req_imm[11:5], req_rs2, req_rs1, 3'd3, req_imm[4:0], OPC_STORE};
         end
         OP_BEQ: begin
            bad_c  = !fits_b;
            enc0_c = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, 3'd0,
                      req_imm[4:1], req_imm[11], OPC_BRANCH};
         end
         OP_LUI:   enc0_c = {req_imm[19:0], req_rd, OPC_LUI};
         OP_AUIPC: enc0_c = {req_imm[19:0], req_rd, OPC_AUIPC};
         OP_JAL: begin
            bad_c  = !fits_j;
            enc0_c = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, OPC_JAL};
         end
         OP_JALR: begin
            bad_c  = !fits_i;
            enc0_c = {imm12, req_rs1, 3'd0, req_rd, OPC_JALR};
         end
         OP_LI: begin
            if (fits_i) begin
               enc0_c = {imm12, 5'd0, 3'd0, req_rd, OPC_OPIMM};
            end else if (req_imm[31:11] == 21'h0F_FFFF) begin
               // Rounding up would carry into bit 31 and LUI would sign-extend wrongly
               bad_c = 1'b1;
            end else begin
               enc0_c = {li_hi, req_rd, OPC_LUI};
               enc1_c = {imm12, req_rd, 3'd0, req_rd, OPC_OPIMM};
               two_c  = (imm12 != 12'd0);
            end
         end
         default: bad_c = 1'b1;
      endcase
   end

   // Ready whenever the slot is empty or the final word leaves this cycle
   always_comb begin
      req_ready = (state_q == IDLE)
                | ((state_q == OUT0) & last_q & out_ready)
                | ((state_q == OUT1) & out_ready);
   end

   always_comb begin
      state_d  = state_q;
      instr_d  = instr_q;
      second_d = second_q;
      last_d   = last_q;
      err_d    = 1'b0;
      accept_c = req_valid & req_ready;

      if ((state_q == OUT0) && out_ready && !last_q) begin
         state_d = OUT1;
         instr_d = second_q;
         last_d  = 1'b1;
      end else begin
         if ((state_q != IDLE) && out_ready) begin
            state_d = IDLE;
         end
         if (accept_c) begin
            if (bad_c) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               state_d  = OUT0;
               instr_d  = enc0_c;
               second_d = enc1_c;
               last_d   = !two_c;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= IDLE;
         instr_q  <= '0;
         second_q <= '0;
         last_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         instr_q  <= instr_d;
         second_q <= second_d;
         last_q   <= last_d;
         err_q    <= err_d;
      end
   end

   assign out_valid = (state_q != IDLE);
   assign out_instr = instr_q;
   assign out_last  = last_q;
   assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed literal cases followed by random traffic,
// all checked every cycle against a word-queue reference model.
module tb_instr_encoder;

   logic        clk;
   logic        resetn;
   logic        req_valid;
   logic        req_ready;
   logic [4:0]  req_op;
   logic [4:0]  req_rd;
   logic [4:0]  req_rs1;
   logic [4:0]  req_rs2;
   logic [31:0] req_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic        out_last;
   logic        err;

   int vectors = 0;
   int errors  = 0;

   // Model: words still to be emitted for the current request, {last, instr}
   logic [32:0] q[$];
   logic        exp_err;

   instr_encoder #(.OPW(5)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_rd    (req_rd),
      .req_rs1   (req_rs1),
      .req_rs2   (req_rs2),
      .req_imm   (req_imm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_last  (out_last),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] fmt_r(int f7, int rs2, int rs1, int f3, int rd, int opc);
      return 32'((longint'(f7) << 25) + (longint'(rs2) << 20) + (longint'(rs1) << 15)
               + (longint'(f3) << 12) + (longint'(rd) << 7) + longint'(opc));
   endfunction

   function automatic logic [31:0] fmt_i(longint imm, int rs1, int f3, int rd, int opc);
      return 32'(((imm & 64'hFFF) << 20) + (longint'(rs1) << 15) + (longint'(f3) << 12)
               + (longint'(rd) << 7) + longint'(opc));
   endfunction

   function automatic logic [31:0] fmt_s(longint imm, int rs2, int rs1, int f3, int opc);
      return 32'((((imm >>> 5) & 64'h7F) << 25) + (longint'(rs2) << 20) + (longint'(rs1) << 15)
               + (longint'(f3) << 12) + ((imm & 64'h1F) << 7) + longint'(opc));
   endfunction

   function automatic logic [31:0] fmt_b(longint imm, int rs2, int rs1);
      return 32'((((imm >>> 12) & 64'h1) << 31) + (((imm >>> 5) & 64'h3F) << 25)
               + (longint'(rs2) << 20) + (longint'(rs1) << 15)
               + (((imm >>> 1) & 64'hF) << 8) + (((imm >>> 11) & 64'h1) << 7) + 64'h63);
   endfunction

   function automatic logic [31:0] fmt_u(longint v, int rd, int opc);
      return 32'(((v & 64'hFFFFF) << 12) + (longint'(rd) << 7) + longint'(opc));
   endfunction

   function automatic logic [31:0] fmt_j(longint imm, int rd);
      return 32'((((imm >>> 20) & 64'h1) << 31) + (((imm >>> 1) & 64'h3FF) << 21)
               + (((imm >>> 11) & 64'h1) << 20) + (((imm >>> 12) & 64'hFF) << 12)
               + (longint'(rd) << 7) + 64'h6F);
   endfunction

   function automatic bit in_rng(longint s, longint lo, longint hi);
      return (s >= lo) && (s <= hi);
   endfunction

   // n = number of words (0 means rejected)
   function automatic void model_enc(input int op, input int rd, input int rs1, input int rs2,
                                     input logic [31:0] imm, output int n,
                                     output logic [31:0] w0, output logic [31:0] w1);
      longint s, hi, lo;
      int     f3;
      s  = longint'($signed(imm));
      n  = 1;
      w0 = '0;
      w1 = '0;
      case (op % 5)
         2: f3 = 4;
         3: f3 = 6;
         4: f3 = 7;
         default: f3 = 0;
      endcase
      if (op <= 4) begin
         w0 = fmt_r((op == 1) ? 32 : 0, rs2, rs1, f3, rd, 'h33);
      end else if (op <= 8) begin
         case (op)
            6: f3 = 4;
            7: f3 = 6;
            8: f3 = 7;
            default: f3 = 0;
         endcase
         if (!in_rng(s, -2048, 2047)) n = 0;
         else w0 = fmt_i(s, rs1, f3, rd, 'h13);
      end else begin
         case (op)
            9:  if (!in_rng(s, -2048, 2047)) n = 0; else w0 = fmt_i(s, rs1, 3, rd, 'h03);
            10: if (!in_rng(s, -2048, 2047)) n = 0; else w0 = fmt_s(s, rs2, rs1, 3, 'h23);
            11: if (!in_rng(s, -4096, 4094) || (s & 1) != 0) n = 0; else w0 = fmt_b(s, rs2, rs1);
            12: w0 = fmt_u(s, rd, 'h37);
            13: w0 = fmt_u(s, rd, 'h17);
            14: if (!in_rng(s, -1048576, 1048574) || (s & 1) != 0) n = 0; else w0 = fmt_j(s, rd);
            15: if (!in_rng(s, -2048, 2047)) n = 0; else w0 = fmt_i(s, rs1, 0, rd, 'h67);
            16: begin
               if (in_rng(s, -2048, 2047)) begin
                  w0 = fmt_i(s, 0, 0, rd, 'h13);
               end else if (s >= 2147481600) begin
                  n = 0;
               end else begin
                  hi = (s + 2048) >>> 12;
                  lo = s & 64'hFFF;
                  w0 = fmt_u(hi, rd, 'h37);
                  if (lo != 0) begin
                     n  = 2;
                     w1 = fmt_i(lo, rd, 0, rd, 'h13);
                  end
               end
            end
            default: n = 0;
         endcase
      end
   endfunction

   task automatic check_cycle();
      cmp("out_valid", 32'(out_valid), 32'(q.size() != 0));
      cmp("req_ready", 32'(req_ready), 32'((q.size() == 0) || (q.size() == 1 && out_ready)));
      cmp("err", 32'(err), 32'(exp_err));
      if (q.size() != 0) begin
         cmp("out_instr", out_instr, q[0][31:0]);
         cmp("out_last", 32'(out_last), 32'(q[0][32]));
      end
   endtask

   task automatic model_update();
      bit          acc;
      int          n;
      logic [31:0] w0, w1;
      if (!resetn) begin
         q.delete();
         exp_err = 1'b0;
      end else begin
         acc     = req_valid && ((q.size() == 0) || (q.size() == 1 && out_ready));
         exp_err = 1'b0;
         if (q.size() != 0 && out_ready) void'(q.pop_front());
         if (acc) begin
            model_enc(int'(req_op), int'(req_rd), int'(req_rs1), int'(req_rs2), req_imm, n, w0, w1);
            if (n == 0) exp_err = 1'b1;
            else q.push_back({(n == 1), w0});
            if (n == 2) q.push_back({1'b1, w1});
         end
      end
   endtask

   // One clock: drive, check mid-cycle, advance model at the edge
   task automatic step(input bit rv, input int op, input int rd, input int rs1, input int rs2,
                       input logic [31:0] imm, input bit ordy);
      req_valid = rv;
      req_op    = 5'(op);
      req_rd    = 5'(rd);
      req_rs1   = 5'(rs1);
      req_rs2   = 5'(rs2);
      req_imm   = imm;
      out_ready = ordy;
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      model_update();
      #1;
   endtask

   logic [31:0] bnd [16] = '{32'd2047, 32'd2048, -32'd2048, -32'd2049, 32'd4094, 32'd4095,
                             -32'd4096, -32'd4098, 32'd1048574, 32'd1048576, -32'd1048576,
                             32'h7FFF_F800, 32'h7FFF_FFFF, 32'h0000_0800, 32'h0000_1000,
                             32'h8000_0000};

   initial begin
      int          n;
      logic [31:0] w0, w1;
      int          op;
      logic [31:0] imm;

      // Pin the model against hand-encoded words
      model_enc(1, 3, 1, 2, 32'd0, n, w0, w1);         cmp("model_sub", w0, 32'h402081B3);
      model_enc(11, 0, 1, 2, 32'd8, n, w0, w1);        cmp("model_beq", w0, 32'h00208463);
      model_enc(14, 1, 0, 0, 32'd8, n, w0, w1);        cmp("model_jal", w0, 32'h008000EF);
      model_enc(16, 5, 0, 0, 32'h12345678, n, w0, w1);
      cmp("model_li_n", 32'(n), 32'd2);
      cmp("model_li_w0", w0, 32'h123452B7);
      cmp("model_li_w1", w1, 32'h67828293);
      model_enc(16, 5, 0, 0, 32'h00010000, n, w0, w1);
      cmp("model_li_lui_only", w0, 32'h000102B7);
      cmp("model_li_lui_n", 32'(n), 32'd1);

      q.delete();
      exp_err   = 1'b0;
      resetn    = 1'b0;
      req_valid = 1'b0;
      req_op    = '0;
      req_rd    = '0;
      req_rs1   = '0;
      req_rs2   = '0;
      req_imm   = '0;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      step(0, 0, 0, 0, 0, 0, 0);
      cmp("rst_valid", 32'(out_valid), 32'd0);
      cmp("rst_instr", out_instr, 32'd0);
      cmp("rst_last", 32'(out_last), 32'd0);
      cmp("rst_err", 32'(err), 32'd0);
      resetn = 1'b1;

      step(1, 5, 1, 0, 0, 32'd5, 1);
      cmp("addi_valid", 32'(out_valid), 32'd1);
      cmp("addi_word", out_instr, 32'h00500093);
      cmp("addi_last", 32'(out_last), 32'd1);

      step(1, 16, 5, 0, 0, 32'h12345678, 1);
      cmp("li_w0", out_instr, 32'h123452B7);
      cmp("li_w0_last", 32'(out_last), 32'd0);
      out_ready = 1'b1;
      #1;
      cmp("li_ready_between", 32'(req_ready), 32'd0);
      step(0, 0, 0, 0, 0, 0, 1);
      cmp("li_w1", out_instr, 32'h67828293);
      cmp("li_w1_last", 32'(out_last), 32'd1);

      step(1, 16, 6, 0, 0, 32'h00001800, 1);
      cmp("li_neg_lo_w0", out_instr, 32'h00002337);
      step(0, 0, 0, 0, 0, 0, 1);
      cmp("li_neg_lo_w1", out_instr, 32'h80030313);

      step(1, 16, 5, 0, 0, 32'hFFFFFFFF, 1);
      cmp("li_small", out_instr, 32'hFFF00293);
      cmp("li_small_last", 32'(out_last), 32'd1);
      step(1, 16, 5, 0, 0, 32'h00010000, 1);
      cmp("li_lui_only", out_instr, 32'h000102B7);
      cmp("li_lui_only_last", 32'(out_last), 32'd1);

      step(1, 10, 0, 1, 2, 32'd8, 1);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0, 0, 0, 0);
         cmp("sd_stall_valid", 32'(out_valid), 32'd1);
         cmp("sd_stall_word", out_instr, 32'h0020B423);
      end
      step(0, 0, 0, 0, 0, 0, 1);
      cmp("sd_drained", 32'(out_valid), 32'd0);

      step(1, 5, 1, 0, 0, 32'd2048, 1);
      cmp("err_addi", 32'(err), 32'd1);
      cmp("err_addi_novalid", 32'(out_valid), 32'd0);
      step(1, 11, 0, 1, 2, 32'd3, 1);
      cmp("err_beq", 32'(err), 32'd1);
      step(1, 16, 5, 0, 0, 32'h7FFFFFFF, 1);
      cmp("err_li_wrap", 32'(err), 32'd1);
      step(1, 20, 1, 1, 1, 32'd0, 1);
      cmp("err_op20", 32'(err), 32'd1);
      step(0, 0, 0, 0, 0, 0, 1);
      cmp("err_pulse_ends", 32'(err), 32'd0);

      step(1, 16, 5, 0, 0, 32'h12345678, 0);
      cmp("rstmid_first", out_instr, 32'h123452B7);
      resetn = 1'b0;
      step(0, 0, 0, 0, 0, 0, 0);
      cmp("rstmid_valid", 32'(out_valid), 32'd0);
      resetn = 1'b1;
      step(0, 0, 0, 0, 0, 0, 1);
      cmp("rstmid_no_second", 32'(out_valid), 32'd0);

      for (int c = 0; c < 4000; c++) begin
         resetn = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
         op = ($urandom_range(0, 19) < 17) ? int'($urandom_range(0, 16)) : int'($urandom_range(17, 31));
         case ($urandom_range(0, 3))
            0: imm = $urandom_range(0, 4095) - 32'd2048;
            1: imm = bnd[$urandom_range(0, 15)];
            2: imm = $urandom();
            default: imm = ($urandom_range(0, 8191) - 32'd4096) & ~32'd1;
         endcase
         step($urandom_range(0, 9) < 6, op, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 31)), imm, $urandom_range(0, 9) < 7);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
